// File: rtl/uart_rx_if.sv
// Received-word stream with error sideband between the UART receiver and its consumer.
interface uart_rx_if #(
  parameter int Word_len = 8
) ();
  logic [Word_len-1:0] rx_data;
  logic                rx_data_valid;
  logic                rx_data_ready;
  logic                rx_parity_err;
  logic                rx_frame_err;
  logic                rx_overrun;

  modport master (
    output rx_data, rx_data_valid, rx_parity_err, rx_frame_err, rx_overrun,
    input  rx_data_ready
  );

  modport slave (
    input  rx_data, rx_data_valid, rx_parity_err, rx_frame_err, rx_overrun,
    output rx_data_ready
  );
endinterface

// File: rtl/uart_rx.sv
// UART receiver: synchronises the line, samples each bit mid-period and presents
// every completed frame on a valid/ready stream with parity/frame/overrun flags.
module uart_rx #(
  parameter int    clk_rate = 50_000_000,
  parameter int    Baud     = 115200,
  parameter int    Word_len = 8,
  parameter string PARITY   = "even"
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       Uart_rx,
  uart_rx_if.master  rx_if
);

  localparam int BAUD_DIV = clk_rate / Baud;
  localparam int HALF     = BAUD_DIV / 2;
  localparam int CNT_W    = $clog2(BAUD_DIV);
  localparam int BIT_W    = $clog2(Word_len) + 1;
  localparam bit PAR_EN   = (PARITY != "none");
  localparam bit PAR_ODD  = (PARITY == "odd");

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(Word_len - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_HIGH
  } state_t;

  state_t              state_q, state_d;
  logic [1:0]          sync_q, sync_d;
  logic [CNT_W-1:0]    baud_cnt_q, baud_cnt_d;
  logic [BIT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [Word_len-1:0] shift_q, shift_d;
  logic                par_bad_q, par_bad_d;
  logic [Word_len-1:0] data_q, data_d;
  logic                valid_q, valid_d;
  logic                perr_q, perr_d;
  logic                ferr_q, ferr_d;
  logic                overrun_q, overrun_d;

  logic rxs;
  logic tick;
  logic accept;
  logic frame_done;

  assign rxs    = sync_q[1];
  assign tick   = (baud_cnt_q == CNT_LAST);
  assign accept = valid_q && rx_if.rx_data_ready;

  always_comb begin
    sync_d     = {sync_q[0], Uart_rx};
    state_d    = state_q;
    baud_cnt_d = baud_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    par_bad_d  = par_bad_q;
    data_d     = data_q;
    valid_d    = valid_q;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
    overrun_d  = 1'b0;
    frame_done = 1'b0;

    if (accept) valid_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        baud_cnt_d = '0;
        if (!rxs) state_d = S_START;
      end
      S_START: begin
        // Re-check the line half a bit in; a short low pulse is a glitch, not a start bit.
        if (baud_cnt_q == CNT_HALF) begin
          baud_cnt_d = '0;
          bit_cnt_d  = '0;
          par_bad_d  = 1'b0;
          state_d    = rxs ? S_IDLE : S_DATA;
        end else begin
          baud_cnt_d = baud_cnt_q + 1'b1;
        end
      end
      S_DATA: begin
        if (tick) begin
          baud_cnt_d = '0;
          shift_d    = {rxs, shift_q[Word_len-1:1]};
          bit_cnt_d  = bit_cnt_q + 1'b1;
          if (bit_cnt_q == BIT_LAST) state_d = PAR_EN ? S_PARITY : S_STOP;
        end else begin
          baud_cnt_d = baud_cnt_q + 1'b1;
        end
      end
      S_PARITY: begin
        if (tick) begin
          baud_cnt_d = '0;
          par_bad_d  = (rxs != ((^shift_q) ^ PAR_ODD));
          state_d    = S_STOP;
        end else begin
          baud_cnt_d = baud_cnt_q + 1'b1;
        end
      end
      S_STOP: begin
        // Leave at mid-stop so an early next start edge is still seen.
        if (tick) begin
          baud_cnt_d = '0;
          frame_done = 1'b1;
          state_d    = rxs ? S_IDLE : S_WAIT_HIGH;
        end else begin
          baud_cnt_d = baud_cnt_q + 1'b1;
        end
      end
      S_WAIT_HIGH: begin
        if (rxs) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (frame_done) begin
      if (!valid_q || accept) begin
        data_d  = shift_q;
        perr_d  = PAR_EN ? par_bad_q : 1'b0;
        ferr_d  = !rxs;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q     <= 2'b11;
      state_q    <= S_IDLE;
      baud_cnt_q <= '0;
      bit_cnt_q  <= '0;
      par_bad_q  <= 1'b0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      sync_q     <= sync_d;
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      par_bad_q  <= par_bad_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      overrun_q  <= overrun_d;
    end
  end

  // The shift register only feeds data_q after a full frame, so it needs no reset.
  always_ff @(posedge clk) begin
    shift_q <= shift_d;
  end

  assign rx_if.rx_data       = data_q;
  assign rx_if.rx_data_valid = valid_q;
  assign rx_if.rx_parity_err = perr_q;
  assign rx_if.rx_frame_err  = ferr_q;
  assign rx_if.rx_overrun    = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: directed scenarios plus random frames scored against a
// frame-level model (data, parity rule, stop bit) with random consumer back-pressure.
module tb_uart_rx;

  localparam int CLK_RATE = 1_000_000;
  localparam int BAUD     = 100_000;
  localparam int WL       = 8;
  localparam int DIV      = CLK_RATE / BAUD;
  localparam int HALF     = DIV / 2;

  typedef struct packed {
    logic [WL-1:0] d;
    logic          pe;
    logic          fe;
  } word_t;

  logic clk = 1'b0;
  logic rst;
  logic line;

  uart_rx_if #(.Word_len(WL)) bus ();

  uart_rx #(
    .clk_rate(CLK_RATE),
    .Baud    (BAUD),
    .Word_len(WL),
    .PARITY  ("even")
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .Uart_rx(line),
    .rx_if  (bus)
  );

  always #5 clk = ~clk;

  int    n_checks = 0;
  int    n_fail   = 0;
  int    cyc      = 0;
  int    last_start = 0;
  int    last_valid_cyc = 0;
  int    vcycles  = 0;
  int    ovr_pulses = 0;
  int    rdy_mode = 1;   // 0 low, 1 high, 2 random
  word_t got_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Consumer ready driver.
  initial begin
    bus.rx_data_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       bus.rx_data_ready = 1'b0;
        1:       bus.rx_data_ready = 1'b1;
        default: bus.rx_data_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // Stream monitor: collects accepted words, counts overrun/valid cycles, checks hold stability.
  initial begin : monitor
    logic  stall_p;
    logic  valid_p;
    word_t stall_w;
    stall_p = 1'b0;
    valid_p = 1'b0;
    stall_w = '0;
    forever begin
      @(negedge clk);
      if (bus.rx_overrun) ovr_pulses++;
      if (bus.rx_data_valid) vcycles++;
      if (bus.rx_data_valid && !valid_p) last_valid_cyc = cyc;
      if (stall_p && !rst)
        check("hold_stable",
              32'({bus.rx_data_valid, bus.rx_data, bus.rx_parity_err, bus.rx_frame_err}),
              32'({1'b1, stall_w}));
      if (bus.rx_data_valid && bus.rx_data_ready)
        got_q.push_back('{d: bus.rx_data, pe: bus.rx_parity_err, fe: bus.rx_frame_err});
      stall_p = bus.rx_data_valid && !bus.rx_data_ready && !rst;
      stall_w = '{d: bus.rx_data, pe: bus.rx_parity_err, fe: bus.rx_frame_err};
      valid_p = bus.rx_data_valid;
    end
  end

  function automatic logic even_bit(input logic [WL-1:0] d);
    int ones = 0;
    for (int i = 0; i < WL; i++) ones += int'(d[i]);
    return logic'(ones % 2);
  endfunction

  task automatic drive_bit(input logic b);
    line = b;
    repeat (DIV) @(posedge clk);
    #1;
  endtask

  // Line is left at the stop-bit level on return.
  task automatic send_frame(input logic [WL-1:0] d, input logic pbit, input logic sbit);
    @(posedge clk);
    #1;
    last_start = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < WL; i++) drive_bit(d[i]);
    drive_bit(pbit);
    drive_bit(sbit);
  endtask

  task automatic expect_word(input string tag, input logic [WL-1:0] d,
                             input logic pe, input logic fe);
    word_t w;
    int    n = 0;
    while (got_q.size() == 0 && n < 4 * DIV) begin
      @(negedge clk);
      n++;
    end
    if (got_q.size() == 0) begin
      check({tag, "_timeout"}, 32'(0), 32'(1));
    end else begin
      w = got_q.pop_front();
      check({tag, "_data"}, 32'(w.d), 32'(d));
      check({tag, "_perr"}, 32'(w.pe), 32'(pe));
      check({tag, "_ferr"}, 32'(w.fe), 32'(fe));
    end
  endtask

  task automatic check_outputs_reset(input string tag);
    check(tag, 32'({bus.rx_data, bus.rx_data_valid, bus.rx_parity_err,
                    bus.rx_frame_err, bus.rx_overrun}), 32'(0));
  endtask

  initial begin
    logic [WL-1:0] d;
    logic          bad;

    rst  = 1'b1;
    line = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_outputs_reset("reset_state");
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (2 * DIV) @(posedge clk);

    // 1: clean 0xA5, latency and single-cycle valid
    vcycles = 0;
    send_frame(8'hA5, even_bit(8'hA5), 1'b1);
    expect_word("t1", 8'hA5, 1'b0, 1'b0);
    check("t1_latency", 32'(last_valid_cyc - last_start), 32'(3 + HALF + (WL + 2) * DIV));
    repeat (DIV) @(posedge clk);
    check("t1_valid_cycles", 32'(vcycles), 32'(1));

    // 2: wrong parity
    send_frame(8'h3C, ~even_bit(8'h3C), 1'b1);
    expect_word("t2", 8'h3C, 1'b1, 1'b0);

    // 3: stop bit low, line held low, then a clean frame
    send_frame(8'h55, even_bit(8'h55), 1'b0);
    repeat (30) @(posedge clk);
    #1 line = 1'b1;
    expect_word("t3", 8'h55, 1'b0, 1'b1);
    repeat (3 * DIV) @(posedge clk);
    check("t3_quiet", 32'(got_q.size()), 32'(0));
    send_frame(8'h12, even_bit(8'h12), 1'b1);
    expect_word("t3_next", 8'h12, 1'b0, 1'b0);

    // 4: short glitch shorter than half a bit
    vcycles = 0;
    @(posedge clk);
    #1 line = 1'b0;
    repeat (3) @(posedge clk);
    #1 line = 1'b1;
    repeat (5 * DIV) @(posedge clk);
    check("t4_no_valid", 32'(vcycles), 32'(0));
    send_frame(8'h81, even_bit(8'h81), 1'b1);
    expect_word("t4_next", 8'h81, 1'b0, 1'b0);

    // 5: back-pressure with overrun
    rdy_mode   = 0;
    repeat (2) @(posedge clk);
    ovr_pulses = 0;
    send_frame(8'h11, even_bit(8'h11), 1'b1);
    send_frame(8'h22, even_bit(8'h22), 1'b1);
    repeat (2 * DIV) @(posedge clk);
    @(negedge clk);
    check("t5_overrun_pulses", 32'(ovr_pulses), 32'(1));
    check("t5_held_data", 32'(bus.rx_data), 32'h11);
    check("t5_held_valid", 32'(bus.rx_data_valid), 32'(1));
    rdy_mode = 1;
    expect_word("t5_accept", 8'h11, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("t5_valid_drop", 32'(bus.rx_data_valid), 32'(0));
    check("t5_no_second", 32'(got_q.size()), 32'(0));

    // 6: reset mid-frame while a word is held
    rdy_mode = 0;
    send_frame(8'h5A, even_bit(8'h5A), 1'b1);
    repeat (DIV) @(posedge clk);
    fork
      send_frame(8'hF0, even_bit(8'hF0), 1'b1);
      begin
        @(posedge clk);
        #1;
        repeat (5 * DIV + 3) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check_outputs_reset("t6_reset_outputs");
      end
    join
    @(posedge clk);
    #1 rst = 1'b0;
    rdy_mode = 1;
    vcycles  = 0;
    repeat (3 * DIV) @(posedge clk);
    check("t6_no_valid", 32'(vcycles), 32'(0));
    check("t6_no_word", 32'(got_q.size()), 32'(0));
    send_frame(8'h0F, even_bit(8'h0F), 1'b1);
    expect_word("t6_next", 8'h0F, 1'b0, 1'b0);

    // Random frames with random back-pressure
    rdy_mode   = 2;
    ovr_pulses = 0;
    for (int k = 0; k < 24; k++) begin
      d   = WL'($urandom);
      bad = ($urandom_range(0, 3) == 0);
      send_frame(d, even_bit(d) ^ bad, 1'b1);
      expect_word("rnd", d, bad, 1'b0);
      repeat ($urandom_range(0, 15)) @(posedge clk);
    end
    rdy_mode = 1;
    repeat (DIV) @(posedge clk);
    check("rnd_no_overrun", 32'(ovr_pulses), 32'(0));
    check("rnd_leftover", 32'(got_q.size()), 32'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: observed timeout required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
